rtc_secuenciador_lectura: RTL

- Upstream feeder for the per-field time registers (seconds, minutes, hours, day, month, year) that hold values for the VGA display.
- On each start request, runs one read frame on the RTC's multiplexed address/data bus: six register reads in a fixed order.
- For each read it presents the captured byte on dato_out and pulses a one-hot load enable, so exactly one downstream register latches it.

---
 rtl/rtc_secuenciador_lectura.sv | 115 +++++++++++
 1 files changed

// File: rtl/rtc_secuenciador_lectura.sv
// rtc_secuenciador_lectura: reads six RTC time registers per start request over a multiplexed bus
module rtc_secuenciador_lectura #(
    parameter int T_PULSE = 4,
    parameter int T_REC   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       a_d,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_out,
    output logic [5:0] en_reg,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, ADDR_WR, ADDR_REC, DATA_RD, DATA_REC} state_t;
    localparam logic [3:0] LP = 4'(T_PULSE - 1);
    localparam logic [3:0] LR = 4'(T_REC - 1);
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [2:0] idx, idx_d;
    logic [7:0] dato_d;
    logic [5:0] en_d;
    logic       done_d;
    logic       drive_d;
    // next state, phase timer, read index and capture; timer reloads on every state entry
    always_comb begin
        state_d = state;
        cnt_d   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        idx_d   = idx;
        dato_d  = dato_out;
        en_d    = 6'd0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = ADDR_WR;
                    cnt_d   = LP;
                    idx_d   = 3'd0;
                end
            end
            ADDR_WR: begin
                if (cnt == 4'd0) begin
                    state_d = ADDR_REC;
                    cnt_d   = LR;
                end
            end
            ADDR_REC: begin
                if (cnt == 4'd0) begin
                    state_d = DATA_RD;
                    cnt_d   = LP;
                end
            end
            DATA_RD: begin
                if (cnt == 4'd0) begin
                    state_d = DATA_REC;
                    cnt_d   = LR;
                    dato_d  = ad_in;
                    en_d    = 6'd1 << idx;
                end
            end
            DATA_REC: begin
                if (cnt == 4'd0) begin
                    if (idx == 3'd5) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ADDR_WR;
                        cnt_d   = LP;
                        idx_d   = idx + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        drive_d = (state_d == ADDR_WR) || (state_d == ADDR_REC);
    end
    // state register; every bus output is decoded from the next state so it is registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx      <= 3'd0;
            cs_n     <= 1'b1;
            wr_n     <= 1'b1;
            rd_n     <= 1'b1;
            a_d      <= 1'b0;
            ad_oe    <= 1'b0;
            ad_out   <= 8'h00;
            dato_out <= 8'h00;
            en_reg   <= 6'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idx      <= idx_d;
            cs_n     <= !((state_d == ADDR_WR) || (state_d == DATA_RD));
            wr_n     <= state_d != ADDR_WR;
            rd_n     <= state_d != DATA_RD;
            a_d      <= (state_d == DATA_RD) || (state_d == DATA_REC);
            ad_oe    <= drive_d;
            ad_out   <= drive_d ? 8'h21 + {5'd0, idx_d} : 8'h00;
            dato_out <= dato_d;
            en_reg   <= en_d;
            busy     <= state_d != IDLE;
            done     <= done_d;
        end
    end
endmodule
